clock_time_display: RTL and testbench

- Reader end of the time-digit interface: consumes the six BCD digits produced by the clock digit counters (h10, h1, m10, m1, s10, s1) and drives a 6-digit multiplexed 7-segment display.
- Shows a colon indicator and blinks the digit selected for editing while set-time mode is active.
- Sits between the digit counter chain and the board display pins.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/clock_time_display.sv | 141 ++++++++++++++
 tb/tb_clock_time_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock display path.
// Digit slot indices and 7-segment patterns.
package clock_pkg;

  localparam logic [2:0] H10 = 3'd0;
  localparam logic [2:0] H1  = 3'd1;
  localparam logic [2:0] M10 = 3'd2;
  localparam logic [2:0] M1  = 3'd3;
  localparam logic [2:0] S10 = 3'd4;
  localparam logic [2:0] S1  = 3'd5;

  localparam logic [2:0] SLOT_LAST = S1;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern.
// Non-decimal codes show a dash as an error marker.
module seg7_decode
  import clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup, no state
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_time_display.sv
// Six-digit multiplexed 7-segment time display.
// Coherent snapshot per scan, colon and edit blink.
module clock_time_display
  import clock_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_DIV      = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLKk,
  input  logic       RST_n,
  input  logic [3:0] h10,
  input  logic [3:0] h1,
  input  logic [3:0] m10,
  input  logic [3:0] m1,
  input  logic [3:0] s10,
  input  logic [3:0] s1,
  input  logic       set_time_enable,
  input  logic [3:0] edit_digit,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          tick_q;
  logic [2:0]    slot;
  logic [3:0]    snap [6];
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          en_q;
  logic          en_rise;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          blank;
  logic [5:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  assign tick    = (presc == P_LAST);
  assign en_rise = set_time_enable & ~en_q;

  // Scan-slot prescaler
  always_ff @(posedge CLKk or negedge RST_n) begin
    if (!RST_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Slot advance; tick_q marks the output update cycle
  always_ff @(posedge CLKk or negedge RST_n) begin
    if (!RST_n) begin
      slot   <= SLOT_LAST;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      if (tick) slot <= (slot == SLOT_LAST) ? H10 : slot + 3'd1;
    end
  end

  // Latch a whole time at the start of each scan so digits never tear
  always_ff @(posedge CLKk or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 6; i++) snap[i] <= '0;
    end else if (tick && slot == SLOT_LAST) begin
      snap[H10] <= h10;
      snap[H1]  <= h1;
      snap[M10] <= m10;
      snap[M1]  <= m1;
      snap[S10] <= s10;
      snap[S1]  <= s1;
    end
  end

  // Blink phase; entering edit restarts it visible
  always_ff @(posedge CLKk or negedge RST_n) begin
    if (!RST_n) begin
      bcnt  <= '0;
      phase <= 1'b1;
      en_q  <= 1'b0;
    end else begin
      en_q <= set_time_enable;
      if (en_rise) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (bcnt == B_LAST) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Select the snapshot digit for the current slot
  always_comb begin
    cur_digit = snap[H10];
    unique case (slot)
      H10:     cur_digit = snap[H10];
      H1:      cur_digit = snap[H1];
      M10:     cur_digit = snap[M10];
      M1:      cur_digit = snap[M1];
      S10:     cur_digit = snap[S10];
      S1:      cur_digit = snap[S1];
      default: cur_digit = snap[H10];
    endcase
  end

  seg7_decode u_dec (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  assign blank = set_time_enable & ~phase &
                 ({1'b0, slot} == edit_digit);

  // Output registers, refreshed one cycle after each tick
  always_ff @(posedge CLKk or negedge RST_n) begin
    if (!RST_n) begin
      an_r  <= '0;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b0;
    end else if (tick_q) begin
      an_r  <= blank ? 6'b0 : (6'b000001 << slot);
      seg_r <= blank ? SEG_OFF : cur_seg;
      dp_r  <= (slot == H1 || slot == M1) &
               (set_time_enable | phase);
    end
  end

  assign an  = SEG_ACTIVE_LOW ? ~an_r  : an_r;
  assign seg = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;

endmodule

// File: tb/tb_clock_time_display.sv
// Bench for clock_time_display.
// Edge-count arithmetic reference model.
module tb_clock_time_display;

  localparam int R = 4;
  localparam int B = 16;

  logic       CLKk = 1'b0;
  logic       RST_n;
  logic [3:0] d [6];
  logic       en;
  logic [3:0] edit;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int ncmp = 0;
  int nerr = 0;

  int         e;
  int         pbase;
  bit         prev_en;
  logic [3:0] sref [6];
  int         m_slot;
  logic [5:0] x_an;
  logic [6:0] x_seg;
  logic       x_dp;

  logic [6:0] pat [16];

  always #5 CLKk = ~CLKk;

  clock_time_display #(
    .REFRESH_DIV    (R),
    .BLINK_DIV      (B),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .CLKk            (CLKk),
    .RST_n           (RST_n),
    .h10             (d[0]),
    .h1              (d[1]),
    .m10             (d[2]),
    .m1              (d[3]),
    .s10             (d[4]),
    .s1              (d[5]),
    .set_time_enable (en),
    .edit_digit      (edit),
    .an              (an),
    .seg             (seg),
    .dp              (dp)
  );

  task automatic model_reset();
    e = 0;
    pbase = 1;
    prev_en = 1'b0;
    m_slot = 5;
    for (int i = 0; i < 6; i++) sref[i] = 4'd0;
    x_an = '0;
    x_seg = '0;
    x_dp = 1'b0;
  endtask

  // Positions in time follow from the edge count since release
  task automatic model_edge();
    bit ph;
    bit blank;
    int t;
    e++;
    ph = (((e - pbase) / B) % 2) == 0;
    if (e > 1 && (e - 1) % R == 0) begin
      t = (e - 1) / R;
      m_slot = (t - 1) % 6;
      blank = en && (edit == 4'(m_slot)) && !ph;
      x_an  = blank ? 6'b0 : (6'b1 << m_slot);
      x_seg = blank ? 7'h00 : pat[sref[m_slot]];
      x_dp  = (m_slot == 1 || m_slot == 3) && (en || ph);
    end
    if (e % R == 0 && ((e / R) - 1) % 6 == 0)
      for (int i = 0; i < 6; i++) sref[i] = d[i];
    if (en && !prev_en) pbase = e + 1;
    prev_en = en;
  endtask

  task automatic check(input string tag);
    ncmp += 3;
    assert (an === x_an) else begin
      nerr++;
      $error("FAIL %s an: got %b want %b", tag, an, x_an);
    end
    assert (seg === x_seg) else begin
      nerr++;
      $error("FAIL %s seg: got %h want %h", tag, seg, x_seg);
    end
    assert (dp === x_dp) else begin
      nerr++;
      $error("FAIL %s dp: got %b want %b", tag, dp, x_dp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLKk);
    if (RST_n) model_edge();
    @(negedge CLKk);
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_d(input int a, input int b, input int c,
                       input int x, input int y, input int z);
    d[0] = 4'(a); d[1] = 4'(b); d[2] = 4'(c);
    d[3] = 4'(x); d[4] = 4'(y); d[5] = 4'(z);
  endtask

  initial begin
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
    pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
    pat[8] = 7'h7F; pat[9] = 7'h6F;
    for (int i = 10; i < 16; i++) pat[i] = 7'h40;

    RST_n = 1'b0;
    en = 1'b0;
    edit = 4'd0;
    set_d(1, 2, 3, 4, 5, 6);
    model_reset();
    run(3, "reset");
    RST_n = 1'b1;
    run(60, "scan");

    for (int i = 0; i < 40 && m_slot != 2; i++) step("seek2");
    set_d(2, 3, 5, 9, 5, 9);
    run(40, "coherent");

    d[2] = 4'hC;
    run(30, "dash");

    en = 1'b1;
    edit = 4'd3;
    run(90, "edit3");

    edit = 4'd7;
    run(40, "edit7");

    en = 1'b0;
    edit = 4'd0;
    run(20, "exit");

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 6; i++) d[i] = 4'($urandom_range(0, 15));
      en = 1'($urandom);
      edit = 4'($urandom_range(0, 7));
      run($urandom_range(5, 40), "rand");
    end

    en = 1'b0;
    step("pre_rst");
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    check("async_rst");
    run(2, "in_rst");
    set_d(9, 8, 7, 6, 5, 4);
    RST_n = 1'b1;
    run(40, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
